// File: rtl/tc_trig_pkg.sv
// Shared types and constants for the TC trigger detector: FSM encoding,
// sample-word slice positions and a state decode helper.
package tc_trig_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LOW = 3'd1,
    ARMED    = 3'd2,
    QUALIFY  = 3'd3,
    HOLDOFF  = 3'd4
  } trig_state_e;

  localparam int X0_MSB  = 31;
  localparam int X0_LSB  = 16;
  localparam int X0Z_MSB = 15;
  localparam int X0Z_LSB = 0;

  function automatic logic state_is_busy(input trig_state_e st);
    case (st)
      ARMED, QUALIFY, HOLDOFF: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tc_trigger_detect_if.sv
// Sample stream from the TC delay FIFO and the trigger result bus.
// master = stream source / trigger consumer, slave = the detector.
interface tc_trigger_detect_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      fifo_tc_dataout;
  logic             trigger_tc_ready;
  logic             trig_enable;
  logic             trig_pulse;
  logic [15:0]      trig_x0_o;
  logic [15:0]      trig_x0z_o;
  logic [CNT_W-1:0] trig_count;
  logic             trig_busy;

  modport master (
    output fifo_tc_dataout,
    output trigger_tc_ready,
    output trig_enable,
    input  trig_pulse,
    input  trig_x0_o,
    input  trig_x0z_o,
    input  trig_count,
    input  trig_busy
  );

  modport slave (
    input  fifo_tc_dataout,
    input  trigger_tc_ready,
    input  trig_enable,
    output trig_pulse,
    output trig_x0_o,
    output trig_x0z_o,
    output trig_count,
    output trig_busy
  );

endinterface

// File: rtl/tc_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// W must be at least 2.
module tc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Count register: clear wins, then increment unless already saturated
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != ALL_ONES)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/tc_trigger_detect.sv
// Hysteresis + minimum-width threshold trigger on the delayed TC x0 stream,
// with post-trigger holdoff, sample capture and a saturating fire count.
module tc_trigger_detect
  import tc_trig_pkg::*;
#(
  parameter logic signed [15:0] THRESH_HI   = 16'sd2000,
  parameter logic signed [15:0] THRESH_LO   = 16'sd1000,
  parameter int                 MIN_WIDTH   = 3,
  parameter int                 HOLDOFF_NUM = 64,
  parameter int                 CNT_W       = 16
) (
  input logic                clk,
  input logic                rst,
  tc_trigger_detect_if.slave bus
);

  localparam logic [7:0]  RUN_TARGET = 8'(MIN_WIDTH);
  localparam logic [15:0] HOLD_INIT  = 16'(HOLDOFF_NUM - 1);
  localparam logic        SINGLE_HIT = (MIN_WIDTH == 1);

  logic               s_valid_r;
  logic signed [15:0] s_x0_r;
  logic [15:0]        s_x0z_r;

  trig_state_e        state_r;
  trig_state_e        state_s;
  logic [7:0]         run_r;
  logic [7:0]         run_s;
  logic [7:0]         run_inc_s;
  logic [15:0]        hold_r;
  logic [15:0]        hold_s;

  logic               hi_s;
  logic               lo_s;
  logic               abort_s;
  logic               fire_s;

  logic               pulse_r;
  logic [15:0]        x0_cap_r;
  logic [15:0]        x0z_cap_r;
  logic [CNT_W-1:0]   count_s;

  // Input stage: valid always tracks ready, data only loads on ready
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid_r <= 1'b0;
      s_x0_r    <= 16'sd0;
      s_x0z_r   <= 16'd0;
    end else begin
      s_valid_r <= bus.trigger_tc_ready;
      if (bus.trigger_tc_ready) begin
        s_x0_r  <= bus.fifo_tc_dataout[X0_MSB:X0_LSB];
        s_x0z_r <= bus.fifo_tc_dataout[X0Z_MSB:X0Z_LSB];
      end else begin
        s_x0_r  <= s_x0_r;
        s_x0z_r <= s_x0z_r;
      end
    end
  end

  // Both operands are signed, so these are two's-complement compares
  assign hi_s      = s_valid_r & (s_x0_r >= THRESH_HI);
  assign lo_s      = s_valid_r & (s_x0_r <= THRESH_LO);
  assign abort_s   = (state_r != IDLE) & (~bus.trig_enable | ~s_valid_r);
  assign run_inc_s = run_r + 8'd1;

  // FSM, run and holdoff counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      run_r   <= 8'd0;
      hold_r  <= 16'd0;
    end else begin
      state_r <= state_s;
      run_r   <= run_s;
      hold_r  <= hold_s;
    end
  end

  // Next-state logic; abort takes priority over any fire condition
  always_comb begin
    state_s = state_r;
    run_s   = run_r;
    hold_s  = hold_r;
    fire_s  = 1'b0;
    if (abort_s) begin
      state_s = IDLE;
      run_s   = 8'd0;
      hold_s  = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.trig_enable && s_valid_r) begin
            state_s = WAIT_LOW;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_LOW: begin
          if (lo_s) begin
            state_s = ARMED;
          end else begin
            state_s = WAIT_LOW;
          end
        end
        ARMED: begin
          if (hi_s && SINGLE_HIT) begin
            fire_s  = 1'b1;
            run_s   = 8'd0;
            hold_s  = HOLD_INIT;
            state_s = HOLDOFF;
          end else if (hi_s) begin
            run_s   = 8'd1;
            state_s = QUALIFY;
          end else begin
            state_s = ARMED;
          end
        end
        QUALIFY: begin
          if (hi_s && (run_inc_s == RUN_TARGET)) begin
            fire_s  = 1'b1;
            run_s   = 8'd0;
            hold_s  = HOLD_INIT;
            state_s = HOLDOFF;
          end else if (hi_s) begin
            run_s   = run_inc_s;
            state_s = QUALIFY;
          end else begin
            run_s   = 8'd0;
            state_s = ARMED;
          end
        end
        HOLDOFF: begin
          if (hold_r == 16'd0) begin
            state_s = WAIT_LOW;
          end else begin
            hold_s  = hold_r - 16'd1;
            state_s = HOLDOFF;
          end
        end
        default: begin
          state_s = IDLE;
          run_s   = 8'd0;
          hold_s  = 16'd0;
        end
      endcase
    end
  end

  // Trigger strobe and capture of the firing sample
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_r   <= 1'b0;
      x0_cap_r  <= 16'd0;
      x0z_cap_r <= 16'd0;
    end else begin
      pulse_r <= fire_s;
      if (fire_s) begin
        x0_cap_r  <= s_x0_r;
        x0z_cap_r <= s_x0z_r;
      end else begin
        x0_cap_r  <= x0_cap_r;
        x0z_cap_r <= x0z_cap_r;
      end
    end
  end

  tc_sat_counter #(
    .W (CNT_W)
  ) u_trig_count (
    .clk   (clk),
    .clr   (rst),
    .inc   (fire_s),
    .count (count_s)
  );

  assign bus.trig_pulse = pulse_r;
  assign bus.trig_x0_o  = x0_cap_r;
  assign bus.trig_x0z_o = x0z_cap_r;
  assign bus.trig_count = count_s;
  assign bus.trig_busy  = state_is_busy(state_r);

endmodule
